// File: rtl/cell_alloc_ctrl.sv
// Cell allocator: circular free-list FIFO of buffer cell indices with round-robin grant to requesters.
// Optional macro CELL_ALLOC_DFREE_CHECK_EN adds an in-use bitmap that drops and flags double frees.

package mem_pkg;
  parameter int NUM_BLOCKS = 64;
  parameter int ADDR_W     = 6;
endpackage

module cell_alloc_ctrl #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      alloc_req,
  output logic [NUM_PORTS-1:0]      alloc_gnt,
  output logic [mem_pkg::ADDR_W-1:0] alloc_idx,
  input  logic                      free_valid,
  input  logic [mem_pkg::ADDR_W-1:0] free_idx,
  output logic                      free_ready,
  output logic                      init_done,
  output logic [mem_pkg::ADDR_W:0]  free_count,
  output logic                      dfree_err
);

  localparam int ADDR_W = mem_pkg::ADDR_W;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_init_cnt;
  logic [ADDR_W-1:0]     r_head;
  logic [ADDR_W-1:0]     r_tail;
  logic [ADDR_W:0]       r_free_count;
  logic                  r_init_done;
  logic [NUM_PORTS-1:0]  r_gnt;
  logic [ADDR_W-1:0]     r_idx;
  logic [PORT_W-1:0]     r_rr_ptr;
  logic [ADDR_W-1:0]     r_mem [NUM_BLOCKS];

  logic                  w_sel_found;
  logic [PORT_W-1:0]     w_sel_port;
  logic [PORT_W:0]       w_cand_sum;
  logic [PORT_W-1:0]     w_cand;
  logic [PORT_W-1:0]     w_rr_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_free_legal;
  logic                  w_mem_we;
  logic [ADDR_W-1:0]     w_mem_waddr;
  logic [ADDR_W-1:0]     w_mem_wdata;

  // Round-robin search: first requester at or after r_rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_port  = '0;
    w_cand_sum  = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand_sum = {1'b0, r_rr_ptr} + (PORT_W+1)'(i);
      if (w_cand_sum >= (PORT_W+1)'(NUM_PORTS))
        w_cand_sum = w_cand_sum - (PORT_W+1)'(NUM_PORTS);
      w_cand = w_cand_sum[PORT_W-1:0];
      if (!w_sel_found && alloc_req[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_port  = w_cand;
      end
    end
  end

  assign w_rr_nxt = (w_sel_port == PORT_W'(NUM_PORTS-1)) ? '0 : w_sel_port + PORT_W'(1);
  assign w_full   = (r_free_count == (ADDR_W+1)'(NUM_BLOCKS));
  assign w_empty  = (r_free_count == '0);
  assign w_pop    = r_init_done && w_sel_found && !w_empty;
  assign w_push   = r_init_done && free_valid && !w_full && w_free_legal;

  // FSM next state and free-list write port (INIT fills slot k with k).
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_waddr = r_tail;
    w_mem_wdata = free_idx;
    case (r_state)
      ST_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_init_cnt;
        w_mem_wdata = r_init_cnt;
        if (r_init_cnt == ADDR_W'(NUM_BLOCKS-1))
          w_state_nxt = ST_READY;
      end
      ST_READY: begin
        w_mem_we = w_push;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_free_count <= '0;
      r_init_done  <= 1'b0;
      r_gnt        <= '0;
      r_idx        <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= '0;
      if (r_state == ST_INIT)
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      if (r_state == ST_READY && !r_init_done) begin
        // First READY cycle: list is full, head == tail == 0.
        r_init_done  <= 1'b1;
        r_free_count <= (ADDR_W+1)'(NUM_BLOCKS);
        r_head       <= '0;
        r_tail       <= '0;
      end else begin
        if (w_pop) begin
          r_gnt    <= NUM_PORTS'(1) << w_sel_port;
          r_idx    <= r_mem[r_head];
          r_head   <= r_head + ADDR_W'(1);
          r_rr_ptr <= w_rr_nxt;
        end
        if (w_push)
          r_tail <= r_tail + ADDR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_free_count <= r_free_count + (ADDR_W+1)'(1);
          2'b01:   r_free_count <= r_free_count - (ADDR_W+1)'(1);
          default: r_free_count <= r_free_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[w_mem_waddr] <= w_mem_wdata;
  end

`ifdef CELL_ALLOC_DFREE_CHECK_EN
  logic [NUM_BLOCKS-1:0] r_in_use;
  logic                  r_dfree_err;

  assign w_free_legal = r_in_use[free_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_use    <= '0;
      r_dfree_err <= 1'b0;
    end else begin
      // Popped head and accepted free can never name the same cell.
      if (w_pop)
        r_in_use[r_mem[r_head]] <= 1'b1;
      if (w_push)
        r_in_use[free_idx] <= 1'b0;
      if (r_init_done && free_valid && !r_in_use[free_idx])
        r_dfree_err <= 1'b1;
    end
  end

  assign dfree_err = r_dfree_err;
`else
  assign w_free_legal = 1'b1;
  assign dfree_err    = 1'b0;
`endif

  assign alloc_gnt  = r_gnt;
  assign alloc_idx  = r_idx;
  assign free_ready = r_init_done;
  assign init_done  = r_init_done;
  assign free_count = r_free_count;

endmodule
